// File: rtl/gd_param_updater_if.sv
// Handshake and data bundle between the gradient-descent updater, the gradient
// unit and the convergence checker. Q8.8 values travel as raw 16-bit words.
interface gd_param_updater_if #(
  parameter int MAX_ITER = 50
);
  localparam int ITER_W = $clog2(MAX_ITER + 1);

  logic              start;
  logic [15:0]       a_init, b_init, c_init, d_init;
  logic              grad_ready;
  logic              grad_valid;
  logic [15:0]       a_grad, b_grad, c_grad, d_grad;
  logic [15:0]       a_current, b_current, c_current, d_current;
  logic [15:0]       a_step, b_step, c_step, d_step;
  logic              check_enable;
  logic [ITER_W-1:0] iter_count;
  logic              converged;
  logic              busy;
  logic              done;
  logic              conv_flag;
  logic              timeout;

  modport master (
    output start, a_init, b_init, c_init, d_init,
    output grad_valid, a_grad, b_grad, c_grad, d_grad, converged,
    input  grad_ready, a_current, b_current, c_current, d_current,
    input  a_step, b_step, c_step, d_step,
    input  check_enable, iter_count, busy, done, conv_flag, timeout
  );

  modport slave (
    input  start, a_init, b_init, c_init, d_init,
    input  grad_valid, a_grad, b_grad, c_grad, d_grad, converged,
    output grad_ready, a_current, b_current, c_current, d_current,
    output a_step, b_step, c_step, d_step,
    output check_enable, iter_count, busy, done, conv_flag, timeout
  );
endinterface

// File: rtl/gd_param_updater.sv
// Iteration sequencer for the 4-parameter gradient-descent loop: fetch gradient,
// apply p <= p - LR*grad with Q8.8 saturation, hand off to the convergence checker.
//
// state | meaning
// IDLE  | waiting for start, results of a previous run held
// REQ   | grad_ready high, waiting for grad_valid
// UPD   | apply saturated steps to all four parameters
// CHK   | check_enable pulse, new parameters on the outputs
// WAIT  | sample converged, decide next iteration or termination
// DONE  | run finished, results held until next start
module gd_param_updater #(
  parameter int                 MAX_ITER      = 50,
  parameter logic signed [15:0] LEARNING_RATE = 16'sh0010
) (
  input logic              clk,
  input logic              rst_n,
  gd_param_updater_if.slave bus
);
  localparam int ITER_W = $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {IDLE, REQ, UPD, CHK, WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic signed [15:0] init_v   [4];
  logic signed [15:0] grad_in  [4];
  logic signed [15:0] grad_q   [4];
  logic signed [15:0] cur_q    [4];
  logic signed [15:0] step_q   [4];
  logic signed [15:0] new_step [4];
  logic signed [15:0] new_cur  [4];
  logic [ITER_W-1:0]  iter_q;
  logic               busy_q, done_q, conv_q, tmo_q;
  logic               at_limit;

  // Product is at most 2^30 in magnitude, so 32 bits hold it exactly.
  function automatic logic signed [15:0] scale_sat(input logic signed [15:0] g);
    logic signed [31:0] prod;
    prod = 32'(g) * 32'(LEARNING_RATE);
    if (!prod[31] && (|prod[30:23]))
      return 16'sh7FFF;
    else if (prod[31] && !(&prod[30:23]))
      return 16'sh8000;
    else
      return prod[23:8];
  endfunction

  function automatic logic signed [15:0] sub_sat(input logic signed [15:0] p,
                                                 input logic signed [15:0] s);
    logic [16:0] diff;
    diff = {p[15], p} - {s[15], s};
    if (diff[16] != diff[15])
      return diff[16] ? 16'sh8000 : 16'sh7FFF;
    else
      return diff[15:0];
  endfunction

  assign init_v[0]  = bus.a_init;
  assign init_v[1]  = bus.b_init;
  assign init_v[2]  = bus.c_init;
  assign init_v[3]  = bus.d_init;
  assign grad_in[0] = bus.a_grad;
  assign grad_in[1] = bus.b_grad;
  assign grad_in[2] = bus.c_grad;
  assign grad_in[3] = bus.d_grad;

  assign at_limit = (iter_q == ITER_W'(MAX_ITER));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      new_step[i] = scale_sat(grad_q[i]);
      new_cur[i]  = sub_sat(cur_q[i], new_step[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = REQ;
      REQ:        if (bus.grad_valid) state_d = UPD;
      UPD:        state_d = CHK;
      CHK:        state_d = WAIT;
      WAIT: begin
        if (bus.converged || at_limit) state_d = DONE;
        else                           state_d = REQ;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cur_q[i]  <= '0;
        step_q[i] <= '0;
        grad_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            iter_q <= '0;
            busy_q <= 1'b1;
            conv_q <= 1'b0;
            tmo_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
              cur_q[i]  <= init_v[i];
              step_q[i] <= '0;
            end
          end
        end
        REQ: begin
          if (bus.grad_valid)
            for (int i = 0; i < 4; i++) grad_q[i] <= grad_in[i];
        end
        UPD: begin
          for (int i = 0; i < 4; i++) begin
            cur_q[i]  <= new_cur[i];
            step_q[i] <= new_step[i];
          end
          if (!at_limit) iter_q <= iter_q + ITER_W'(1);
        end
        WAIT: begin
          // Convergence takes priority over the iteration limit.
          if (bus.converged) begin
            conv_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (at_limit) begin
            tmo_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.grad_ready   = (state_q == REQ);
  assign bus.check_enable = (state_q == CHK);
  assign bus.a_current    = cur_q[0];
  assign bus.b_current    = cur_q[1];
  assign bus.c_current    = cur_q[2];
  assign bus.d_current    = cur_q[3];
  assign bus.a_step       = step_q[0];
  assign bus.b_step       = step_q[1];
  assign bus.c_step       = step_q[2];
  assign bus.d_step       = step_q[3];
  assign bus.iter_count   = iter_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.conv_flag    = conv_q;
  assign bus.timeout      = tmo_q;
endmodule

// File: tb/tb_gd_param_updater.sv
// Directed bench for gd_param_updater: two instances (LR 0.0625 and LR 16.0),
// both with a 5-iteration limit, driven and sampled on the falling clock edge.
module tb_gd_param_updater;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ce_cnt0 = 0;
  int   ce_base;
  bit   stall_ok;

  gd_param_updater_if #(.MAX_ITER(5)) b0 ();
  gd_param_updater_if #(.MAX_ITER(5)) b1 ();

  gd_param_updater #(.MAX_ITER(5), .LEARNING_RATE(16'sh0010)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  gd_param_updater #(.MAX_ITER(5), .LEARNING_RATE(16'sh1000)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (b0.check_enable) ce_cnt0++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Entered at a negedge with u0 in REQ; leaves at the negedge after WAIT.
  task automatic do_iter(input bit conv_in_wait, input bit conv_elsewhere);
    b0.grad_valid = 1'b1;
    b0.converged  = conv_elsewhere;
    nedge();                      // UPD
    nedge();                      // CHK
    b0.grad_valid = 1'b0;
    nedge();                      // WAIT
    b0.converged  = conv_in_wait;
    nedge();                      // REQ or DONE
    b0.converged  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    b0.start = 0; b0.grad_valid = 0; b0.converged = 0;
    b0.a_init = 0; b0.b_init = 0; b0.c_init = 0; b0.d_init = 0;
    b0.a_grad = 0; b0.b_grad = 0; b0.c_grad = 0; b0.d_grad = 0;
    b1.start = 0; b1.grad_valid = 0; b1.converged = 0;
    b1.a_init = 0; b1.b_init = 0; b1.c_init = 0; b1.d_init = 0;
    b1.a_grad = 0; b1.b_grad = 0; b1.c_grad = 0; b1.d_grad = 0;
    repeat (2) nedge();

    chk("rst_a_cur", b0.a_current, 16'h0000);
    chk("rst_a_step", b0.a_step, 16'h0000);
    chk("rst_iter", b0.iter_count, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_ready", b0.grad_ready, 0);
    chk("rst_ce", b0.check_enable, 0);
    chk("rst_flags", {b0.done, b0.conv_flag, b0.timeout}, 0);

    // Basic update
    rst_n = 1'b1;
    b0.a_init = 16'h0200; b0.a_grad = 16'h1000;
    b0.b_init = 16'h0100; b0.b_grad = 16'hF000;
    b0.c_init = 16'h0000; b0.c_grad = 16'h0000;
    b0.d_init = 16'hFFF0; b0.d_grad = 16'h0008;
    b0.grad_valid = 1'b1;
    b0.start = 1'b1;
    nedge();                      // REQ
    b0.start = 1'b0;
    chk("req_ready", b0.grad_ready, 1);
    chk("req_busy", b0.busy, 1);
    chk("load_a", b0.a_current, 16'h0200);
    chk("req_ce", b0.check_enable, 0);
    nedge();                      // UPD
    chk("upd_ce", b0.check_enable, 0);
    chk("upd_a_held", b0.a_current, 16'h0200);
    nedge();                      // CHK
    chk("chk_ce", b0.check_enable, 1);
    chk("basic_a_cur", b0.a_current, 16'h0100);
    chk("basic_a_step", b0.a_step, 16'h0100);
    chk("basic_b_cur", b0.b_current, 16'h0200);
    chk("basic_b_step", b0.b_step, 16'hFF00);
    chk("basic_c_cur", b0.c_current, 16'h0000);
    chk("basic_d_step", b0.d_step, 16'h0000);
    chk("basic_d_cur", b0.d_current, 16'hFFF0);
    chk("basic_iter", b0.iter_count, 1);
    b0.grad_valid = 1'b0;
    nedge();                      // WAIT
    chk("wait_ce", b0.check_enable, 0);
    nedge();                      // REQ, stalled

    // Handshake stall plus a start pulse while busy
    stall_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(b0.grad_ready === 1'b1 && b0.a_current === 16'h0100 &&
            b0.iter_count === 3'd1 && b0.check_enable === 1'b0))
        stall_ok = 1'b0;
      b0.start = (i == 3);
      nedge();
    end
    b0.start = 1'b0;
    chk("stall_hold", stall_ok, 1);
    chk("busy_start_ignored", b0.a_current, 16'h0100);

    // Convergence: converged outside WAIT ignored, then honoured in WAIT of iter 3
    do_iter(1'b0, 1'b1);
    chk("iter2_a", b0.a_current, 16'h0000);
    chk("iter2_iter", b0.iter_count, 2);
    chk("iter2_busy", b0.busy, 1);
    chk("iter2_conv", b0.conv_flag, 0);
    do_iter(1'b1, 1'b0);
    chk("conv_done", b0.done, 1);
    chk("conv_flag", b0.conv_flag, 1);
    chk("conv_timeout", b0.timeout, 0);
    chk("conv_iter", b0.iter_count, 3);
    chk("conv_busy", b0.busy, 0);
    chk("conv_a", b0.a_current, 16'hFF00);
    nedge();
    chk("done_pulse_end", b0.done, 0);
    chk("done_hold_a", b0.a_current, 16'hFF00);

    // Restart from DONE with saturation cases, then run to timeout
    b0.a_init = 16'h7F00; b0.a_grad = 16'h8000;
    b0.b_init = 16'h8100; b0.b_grad = 16'h7FFF;
    b0.c_init = 16'h0000; b0.c_grad = 16'hFFFF;
    b0.d_init = 16'h1234; b0.d_grad = 16'h0000;
    b0.start = 1'b1;
    ce_base = ce_cnt0;
    nedge();                      // REQ
    b0.start = 1'b0;
    chk("restart_flags", {b0.conv_flag, b0.timeout, b0.done}, 0);
    chk("restart_iter", b0.iter_count, 0);
    chk("restart_a", b0.a_current, 16'h7F00);
    chk("restart_step", b0.a_step, 16'h0000);
    do_iter(1'b0, 1'b0);
    chk("sat_a_step", b0.a_step, 16'hF800);
    chk("sat_a_cur", b0.a_current, 16'h7FFF);
    chk("sat_b_step", b0.b_step, 16'h07FF);
    chk("sat_b_cur", b0.b_current, 16'h8000);
    chk("trunc_c_step", b0.c_step, 16'hFFFF);
    chk("trunc_c_cur", b0.c_current, 16'h0001);
    chk("zero_d_cur", b0.d_current, 16'h1234);
    repeat (4) do_iter(1'b0, 1'b0);
    chk("tmo_done", b0.done, 1);
    chk("tmo_flag", b0.timeout, 1);
    chk("tmo_conv", b0.conv_flag, 0);
    chk("tmo_iter", b0.iter_count, 5);
    chk("tmo_busy", b0.busy, 0);
    chk("tmo_ce_count", ce_cnt0 - ce_base, 5);
    chk("tmo_a_sat", b0.a_current, 16'h7FFF);
    chk("tmo_b_sat", b0.b_current, 16'h8000);
    chk("tmo_c", b0.c_current, 16'h0005);
    nedge();
    chk("tmo_iter_hold", b0.iter_count, 5);

    // Large learning rate: step saturation on u1
    b1.a_init = 16'h0000; b1.a_grad = 16'h7FFF;
    b1.b_init = 16'h0200; b1.b_grad = 16'h0010;
    b1.c_init = 16'h0000; b1.c_grad = 16'hFFFF;
    b1.d_init = 16'h0000; b1.d_grad = 16'h8000;
    b1.grad_valid = 1'b1;
    b1.start = 1'b1;
    nedge();                      // REQ
    b1.start = 1'b0;
    nedge();                      // UPD
    nedge();                      // CHK
    chk("lr16_ce", b1.check_enable, 1);
    chk("lr16_a_step", b1.a_step, 16'h7FFF);
    chk("lr16_a_cur", b1.a_current, 16'h8001);
    chk("lr16_b_step", b1.b_step, 16'h0100);
    chk("lr16_b_cur", b1.b_current, 16'h0100);
    chk("lr16_c_step", b1.c_step, 16'hFFF0);
    chk("lr16_c_cur", b1.c_current, 16'h0010);
    chk("lr16_d_step", b1.d_step, 16'h8000);
    chk("lr16_d_cur", b1.d_current, 16'h7FFF);

    // Asynchronous reset in the middle of CHK
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_cur", b1.a_current, 16'h0000);
    chk("arst_a_step", b1.a_step, 16'h0000);
    chk("arst_d_cur", b1.d_current, 16'h0000);
    chk("arst_iter", b1.iter_count, 0);
    chk("arst_busy", b1.busy, 0);
    chk("arst_ce", b1.check_enable, 0);
    chk("arst_u0_tmo", b0.timeout, 0);
    nedge();
    rst_n = 1'b1;
    repeat (3) nedge();
    chk("idle_ready", b1.grad_ready, 0);
    chk("idle_iter", b1.iter_count, 0);
    chk("idle_a", b1.a_current, 16'h0000);
    chk("idle_busy", b1.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gd_param_updater.md
Name: gd_param_updater

Overview:
- Per-iteration driver of the 4-parameter gradient-descent loop.
- Requests gradients from the gradient unit and applies the update p <= p - LR*grad (Q8.8, saturating).
- Presents current parameters, step sizes and a one-cycle check_enable to the downstream convergence checker.
- Samples the checker's converged flag on the following cycle and terminates on convergence or at MAX_ITER.

Parameters:
- MAX_ITER, 50, iteration limit; iter_count width is $clog2(MAX_ITER+1).
- LEARNING_RATE, 16'h0010, signed Q8.8 learning rate (0.0625).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; loads a_init..d_init and begins. Ignored while busy.
- a_init, b_init, c_init, d_init  in  16 each  signed Q8.8 initial parameters.
- grad_ready  out  1  updater is ready to accept a gradient.
- grad_valid  in  1  gradient unit has a gradient for the current parameters.
- a_grad, b_grad, c_grad, d_grad  in  16 each  signed Q8.8 gradients.
- a_current, b_current, c_current, d_current  out  16 each  signed Q8.8 parameters (registered).
- a_step, b_step, c_step, d_step  out  16 each  signed Q8.8 last applied step (registered).
- check_enable  out  1  one-cycle pulse to the convergence checker.
- iter_count  out  $clog2(MAX_ITER+1)  completed updates.
- converged  in  1  from the checker; valid the cycle after check_enable.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- conv_flag  out  1  sticky: run ended by convergence.
- timeout  out  1  sticky: run ended at MAX_ITER without convergence.

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0: parameters, steps, iter_count, grad_ready, check_enable, busy, done, conv_flag, timeout.
  - Reset mid-run aborts immediately; no partial update survives.
- States: IDLE, REQ, UPD, CHK, WAIT, DONE.
- IDLE / DONE, start=1:
  - Load *_current <= *_init; steps <= 0; iter_count <= 0.
  - Clear conv_flag and timeout; busy <= 1; go to REQ.
  - Results are held in IDLE/DONE until the next start.
- REQ:
  - grad_ready = 1 (combinational from state).
  - Transfer occurs when grad_valid && grad_ready: capture all four gradients, go to UPD.
  - No timeout on the handshake; grad_valid outside REQ is ignored.
- UPD (1 cycle), per parameter:
  - prod = signed 16x16 -> 32 bit.
  - step = prod >>> 8 (arithmetic shift, truncation toward -inf), saturated to [16'h8000, 16'h7FFF].
  - new = {p[15],p} - {step[15],step} in 17 bits, saturated to 16 bits.
  - Register *_step and *_current; iter_count <= iter_count + 1; go to CHK.
- CHK (1 cycle): check_enable = 1; outputs are stable and carry the new values. Go to WAIT.
- WAIT (1 cycle): sample converged.
  - converged=1: conv_flag <= 1, go to DONE.
  - Else if iter_count == MAX_ITER: timeout <= 1, go to DONE.
  - Else go to REQ.
  - Convergence wins if both conditions hold.
- DONE entry: done pulses for 1 cycle; busy <= 0.
- Latency: minimum 4 cycles per iteration (REQ with grad_valid already high, UPD, CHK, WAIT).
- iter_count never exceeds MAX_ITER and never wraps.
- The checker's converged outside the WAIT cycle is ignored.

Test Plan:
- Basic update: LR=16'h0010, a_init=16'h0200, a_grad=16'h1000, start, grad_valid held high -> next state a_current=16'h0100, a_step=16'h0100; check_enable pulses exactly 2 cycles after handshake; iter_count=1.
- Parameter saturation: a_init=16'h7F00, a_grad=16'h8000 -> a_step=16'hF800, a_current=16'h7FFF (no wrap). Mirror case: a_init=16'h8100, a_grad=16'h7FFF -> a_current=16'h8000.
- Step saturation and truncation:
  - LR=16'h1000, a_grad=16'h7FFF -> a_step=16'h7FFF.
  - LR=16'h0010, a_grad=16'hFFFF -> a_step=16'hFFFF; a_current increases by 1 LSB.
- Convergence exit: drive converged=1 only in the WAIT cycle of iteration 3 -> done pulse, conv_flag=1, timeout=0, iter_count=3, busy=0. Also assert converged=1 outside WAIT -> ignored.
- Timeout: MAX_ITER=5, converged held 0 -> done after iteration 5, timeout=1, iter_count=5, exactly 5 check_enable pulses. Handshake stall: grad_valid low for 10 cycles in REQ -> grad_ready stays 1 and no parameter change.
- Control corners: start while busy -> ignored; restart from DONE -> flags cleared, init values reloaded. rst_n low during UPD/CHK -> all outputs 0 asynchronously, state IDLE.
